muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage of the xgriscv pipeline. It is the multi-cycle successor to the single-cycle ALU path and is parametrised in operand width. It accepts one operation per start pulse and runs a radix-2 shift/add or shift/subtract loop. It raises busy so the hazard logic can stall IF/ID/EX, then returns the result with a one-cycle done pulse.

Parameters:
XLEN, 32, operand and result width (must be >= 4)
CNTW, $clog2(XLEN)+1, iteration counter width (derived; not overridden)

Ports:
clk      input   1     clock, all state updates on rising edge
reset    input   1     synchronous reset, active-low (reset==0 clears all state at the next rising edge)
startE   input   1     request; sampled only in IDLE or DONE
funct3E  input   3     op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
srcaE    input   XLEN  rs1 operand (dividend / multiplicand)
srcbE    input   XLEN  rs2 operand (divisor / multiplier)
flushE   input   1     kill in-flight op (branch/jump taken in EX)
busyE    output  1     1 in CALC and FIX states
doneE    output  1     1-cycle pulse, resultE valid
resultE  output  XLEN  result, held until the next accepted start

Behaviour:
- States: IDLE, CALC, FIX, DONE. Reset (reset==0 at edge) forces IDLE with busyE=0, doneE=0, resultE=0 and counter=0. This holds regardless of the current state, including mid-CALC.
- Accept: startE=1 at an edge while in IDLE or DONE latches funct3E, srcaE and srcbE. startE in CALC or FIX is ignored and never queued.
- Fast path (accept edge goes directly to DONE, so latency is 1 cycle):
  - DIV/DIVU with srcb=0: quotient = all ones.
  - REM/REMU with srcb=0: result = srca.
  - DIV with srca = most negative value and srcb = -1: quotient = srca.
  - REM with srca = most negative value and srcb = -1: result = 0.
- Normal path: accept goes to CALC, with the counter loaded to XLEN.
  - Signed operands (MULH: both; MULHSU: srca only; DIV/REM: both) are converted to magnitudes on accept, and the result sign is recorded.
  - CALC performs one iteration per cycle on a 2*XLEN-bit product or remainder:quotient register. The counter decrements each cycle; at counter==1, CALC goes to FIX.
  - FIX applies the sign correction (two's complement of the 2*XLEN product, or of quotient/remainder). Remainder sign follows the dividend.
  - FIX then selects the result: MUL takes the low XLEN bits; MULH, MULHSU and MULHU take the high XLEN bits; DIV/DIVU take the quotient; REM/REMU take the remainder. FIX goes to DONE.
  - Total latency from accept edge to doneE high is XLEN+2 cycles. busyE is high for XLEN+1 cycles.
- DONE:
  - doneE=1 for exactly one cycle.
  - Goes to IDLE, or to a new operation if startE=1 (back-to-back issue is allowed, no bubble).
  - resultE updates only on the edge entering DONE and is stable otherwise.
- Flush:
  - flushE=1 at an edge in CALC or FIX: next state IDLE, no doneE, resultE unchanged.
  - flushE=1 in IDLE/DONE together with startE=1: the start is dropped.
  - flushE has priority over startE; reset has priority over both.
- Arithmetic: all internal adders are XLEN+1 bits wide. There is no overflow flag, and results wrap modulo 2^XLEN as the ISA defines.

Test Plan:
1. MUL: srca=7, srcb=-3 (0xFFFFFFFD), XLEN=32 -> doneE exactly 34 cycles after the accept edge, resultE=0xFFFFFFEB; busyE high for 33 cycles.
2. MULH/MULHU/MULHSU: srca=0x80000000, srcb=0x80000000 -> MULH result 0x40000000, MULHU 0x40000000, MULHSU 0xC0000000.
3. DIV/REM: srca=-7, srcb=2 -> DIV -3 (0xFFFFFFFD), REM -1 (0xFFFFFFFF). DIVU with srca=0xFFFFFFF9, srcb=2 -> 0x7FFFFFFC.
4. Fast path: DIVU x/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000. Each has doneE 1 cycle after accept and busyE never high.
5. Flush and reset:
   - flushE pulsed at CALC cycle 10 -> IDLE, no doneE, resultE keeps its previous value.
   - reset=0 mid-CALC -> all outputs 0 next cycle.
   - startE while busy -> ignored.
6. Back-to-back and parametrisation: startE held high in the DONE cycle starts a second MUL with no idle cycle, giving done pulses 34 cycles apart. XLEN=8 build with DIVU 200/7 -> 28 after 10 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift/add multiply, restoring divide,
// one iteration per cycle, with a one-cycle fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter  int XLEN = 32,
  localparam int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            startE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] srcaE,
  input  logic [XLEN-1:0] srcbE,
  input  logic            flushE,
  output logic            busyE,
  output logic            doneE,
  output logic [XLEN-1:0] resultE
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state, w_next;
  logic [2:0]        r_op;
  logic [CNTW-1:0]   r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic              r_negq, r_negr;
  logic [XLEN-1:0]   r_result;

  logic              w_accept, w_is_div, w_a_sgn, w_b_sgn, w_b_zero, w_ovf, w_fast;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_fast_res;
  logic [XLEN:0]     w_madd, w_dsh, w_dsub;
  logic              w_dge;
  logic [2*XLEN-1:0] w_mul_step, w_div_step, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;

  assign w_accept = startE && !flushE && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_is_div = funct3E[2];
  assign w_a_sgn  = srcaE[XLEN-1] && ((funct3E == 3'b001) || (funct3E == 3'b010) ||
                                      (funct3E == 3'b100) || (funct3E == 3'b110));
  assign w_b_sgn  = srcbE[XLEN-1] && ((funct3E == 3'b001) || (funct3E == 3'b100) ||
                                      (funct3E == 3'b110));
  assign w_a_mag  = w_a_sgn ? -srcaE : srcaE;
  assign w_b_mag  = w_b_sgn ? -srcbE : srcbE;
  assign w_b_zero = (srcbE == '0);
  assign w_ovf    = !funct3E[0] && (srcaE == MINV) && (srcbE == '1);
  assign w_fast   = w_is_div && (w_b_zero || w_ovf);
  assign w_fast_res = w_b_zero ? (funct3E[1] ? srcaE : '1)
                               : (funct3E[1] ? '0    : srcaE);

  // Multiply: conditionally add multiplicand into the high half, then shift the whole pair right.
  assign w_madd     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_step = {w_madd, r_acc[XLEN-1:1]};

  // Divide: shift remainder:quotient left, trial-subtract divisor, shift in the quotient bit.
  assign w_dsh      = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_dsub     = w_dsh - {1'b0, r_opnd};
  assign w_dge      = !w_dsub[XLEN];
  assign w_div_step = {(w_dge ? w_dsub[XLEN-1:0] : w_dsh[XLEN-1:0]), r_acc[XLEN-2:0], w_dge};

  assign w_prod = r_negq ? -r_acc : r_acc;
  assign w_quo  = r_negq ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_negr ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = w_rem;
    case (r_op)
      3'b000:                 w_fix_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_quo;
      default:                w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_accept ? (w_fast ? S_DONE : S_CALC) : S_IDLE;
      S_CALC: begin
        if (flushE)                   w_next = S_IDLE;
        else if (r_cnt == CNTW'(1))   w_next = S_FIX;
      end
      S_FIX:   w_next = flushE ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op   <= funct3E;
      r_cnt  <= w_fast ? '0 : CNTW'(XLEN);
      r_acc  <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
      r_opnd <= w_is_div ? w_b_mag : w_a_mag;
      r_negq <= w_a_sgn ^ w_b_sgn;
      r_negr <= w_a_sgn;
      if (w_fast) r_result <= w_fast_res;
    end else if ((r_state == S_CALC) && !flushE) begin
      r_acc <= r_op[2] ? w_div_step : w_mul_step;
      r_cnt <= r_cnt - CNTW'(1);
    end else if ((r_state == S_FIX) && !flushE) begin
      r_result <= w_fix_res;
    end
  end

  assign busyE   = (r_state == S_CALC) || (r_state == S_FIX);
  assign doneE   = (r_state == S_DONE);
  assign resultE = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded random/directed bench for muldiv_unit (XLEN=32 plus a small XLEN=8 instance).
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        startE, flushE;
  logic [2:0]  funct3E;
  logic [31:0] srcaE, srcbE;
  logic        busyE, doneE;
  logic [31:0] resultE;

  logic        s8_start, s8_flush;
  logic [2:0]  s8_op;
  logic [7:0]  s8_a, s8_b;
  logic        busy8, done8;
  logic [7:0]  res8;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) u_dut (
    .clk(clk), .reset(reset), .startE(startE), .funct3E(funct3E),
    .srcaE(srcaE), .srcbE(srcbE), .flushE(flushE),
    .busyE(busyE), .doneE(doneE), .resultE(resultE)
  );

  muldiv_unit #(.XLEN(8)) u_dut8 (
    .clk(clk), .reset(reset), .startE(s8_start), .funct3E(s8_op),
    .srcaE(s8_a), .srcbE(s8_b), .flushE(s8_flush),
    .busyE(busy8), .doneE(done8), .resultE(res8)
  );

  typedef struct {
    logic [31:0] res;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  exp_t        q32[$], q8[$];
  exp_t        m32, m8;
  int unsigned cyc = 0;
  int          nvec = 0, nerr = 0;
  logic [31:0] last_res;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model straight from the ISA definitions using 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !op[0] && (a == 32'h80000000) && (b == 32'hFFFFFFFF);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && doneE === 1'b1) begin
      if (q32.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_done32: result %h with nothing outstanding", resultE);
      end else begin
        m32 = q32.pop_front();
        check("result32", resultE, m32.res);
        check("latency32", cyc - m32.acc, m32.lat);
      end
    end
    if (reset === 1'b1 && done8 === 1'b1) begin
      if (q8.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_done8: result %h with nothing outstanding", res8);
      end else begin
        m8 = q8.pop_front();
        check("result8", {24'b0, res8}, m8.res);
        check("latency8", cyc - m8.acc, m8.lat);
      end
    end
  end

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit exp_it);
    exp_t e;
    funct3E = op; srcaE = a; srcbE = b; startE = 1'b1;
    if (exp_it) begin
      e.res = ref_res(op, a, b);
      e.acc = cyc;
      e.lat = is_fast(op, a, b) ? 1 : 34;
      q32.push_back(e);
      last_res = e.res;
    end
    @(negedge clk);
    startE = 1'b0;
  endtask

  // Leaves the caller at the negedge of the done cycle.
  task automatic wait_done(input int exp_busy, input string name);
    int nb = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (doneE) begin seen = 1'b1; break; end
      if (busyE) nb++;
      @(negedge clk);
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_busy_cycles"}, nb, exp_busy);
  endtask

  task automatic idle_watch(input int n, input string name);
    int nb = 0;
    for (int i = 0; i < n; i++) begin
      if (busyE) nb++;
      @(negedge clk);
    end
    check({name, "_busy_after"}, nb, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned c1, c2;
    logic [2:0]  op;
    logic [31:0] a, b;
    exp_t        e;
    bit          seen;
    logic [7:0]  t8 [5][4];

    reset = 1'b0; startE = 1'b0; flushE = 1'b0; funct3E = '0; srcaE = '0; srcbE = '0;
    s8_start = 1'b0; s8_flush = 1'b0; s8_op = '0; s8_a = '0; s8_b = '0;
    last_res = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busyE), 0);
    check("reset_done", 32'(doneE), 0);
    check("reset_result", resultE, 0);
    reset = 1'b1;
    @(negedge clk);

    launch(3'd0, 32'd7, 32'hFFFFFFFD, 1); wait_done(33, "mul");
    check("mul_value", resultE, 32'hFFFFFFEB);
    launch(3'd1, 32'h80000000, 32'h80000000, 1); wait_done(33, "mulh");
    check("mulh_value", resultE, 32'h40000000);
    launch(3'd3, 32'h80000000, 32'h80000000, 1); wait_done(33, "mulhu");
    check("mulhu_value", resultE, 32'h40000000);
    launch(3'd2, 32'h80000000, 32'h80000000, 1); wait_done(33, "mulhsu");
    check("mulhsu_value", resultE, 32'hC0000000);
    launch(3'd4, 32'hFFFFFFF9, 32'd2, 1); wait_done(33, "div");
    check("div_value", resultE, 32'hFFFFFFFD);
    launch(3'd6, 32'hFFFFFFF9, 32'd2, 1); wait_done(33, "rem");
    check("rem_value", resultE, 32'hFFFFFFFF);
    launch(3'd5, 32'hFFFFFFF9, 32'd2, 1); wait_done(33, "divu");
    check("divu_value", resultE, 32'h7FFFFFFC);

    launch(3'd5, 32'h12345, 32'd0, 1); wait_done(0, "fast_divu0");
    check("fast_divu0_value", resultE, 32'hFFFFFFFF);
    launch(3'd6, 32'd5, 32'd0, 1); wait_done(0, "fast_rem0");
    check("fast_rem0_value", resultE, 32'd5);
    launch(3'd4, 32'h80000000, 32'hFFFFFFFF, 1); wait_done(0, "fast_divovf");
    check("fast_divovf_value", resultE, 32'h80000000);
    launch(3'd6, 32'h80000000, 32'hFFFFFFFF, 1); wait_done(0, "fast_removf");
    check("fast_removf_value", resultE, 32'h0);

    // Back-to-back: second start is driven during the DONE cycle of the first.
    launch(3'd0, 32'd12345, 32'd678, 1); wait_done(33, "b2b_first");
    c1 = cyc;
    launch(3'd0, 32'hDEADBEEF, 32'h1234567, 1); wait_done(33, "b2b_second");
    c2 = cyc;
    check("b2b_spacing", c2 - c1, 34);

    // Start while busy must be ignored and not queued.
    launch(3'd4, 32'd1000, 32'd7, 1);
    repeat (5) @(negedge clk);
    funct3E = 3'd0; srcaE = 32'd99; srcbE = 32'd99; startE = 1'b1;
    @(negedge clk);
    startE = 1'b0;
    wait_done(27, "busy_start");
    @(negedge clk);
    idle_watch(40, "busy_start");

    // Flush mid-CALC.
    launch(3'd0, 32'd55, 32'd66, 0);
    repeat (9) @(negedge clk);
    flushE = 1'b1;
    @(negedge clk);
    flushE = 1'b0;
    check("flush_calc_busy", 32'(busyE), 0);
    check("flush_calc_result", resultE, last_res);
    idle_watch(40, "flush_calc");

    // Flush landing in the FIX cycle.
    launch(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    repeat (32) @(negedge clk);
    check("fix_state_busy", 32'(busyE), 1);
    flushE = 1'b1;
    @(negedge clk);
    flushE = 1'b0;
    check("flush_fix_done", 32'(doneE), 0);
    check("flush_fix_result", resultE, last_res);
    idle_watch(40, "flush_fix");

    // Flush together with start in IDLE drops the start.
    flushE = 1'b1;
    launch(3'd5, 32'd9, 32'd0, 0);
    flushE = 1'b0;
    check("flush_start_done", 32'(doneE), 0);
    check("flush_start_busy", 32'(busyE), 0);
    idle_watch(40, "flush_start");

    // Reset mid-CALC.
    launch(3'd5, 32'd123456, 32'd11, 0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", 32'(busyE), 0);
    check("midreset_done", 32'(doneE), 0);
    check("midreset_result", resultE, 0);
    reset = 1'b1;
    last_res = '0;
    idle_watch(40, "midreset");

    for (int n = 0; n < 80; n++) begin
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      launch(op, a, b, 1);
      wait_done(is_fast(op, a, b) ? 0 : 33, "rand");
    end

    // XLEN=8 instance: {op, a, b, expected}.
    t8[0] = '{8'd5, 8'd200, 8'd7, 8'd28};
    t8[1] = '{8'd7, 8'd200, 8'd7, 8'd4};
    t8[2] = '{8'd3, 8'd200, 8'd7, 8'h05};
    t8[3] = '{8'd0, 8'd200, 8'd7, 8'h78};
    t8[4] = '{8'd5, 8'd200, 8'd0, 8'hFF};
    for (int k = 0; k < 5; k++) begin
      s8_op = t8[k][0][2:0]; s8_a = t8[k][1]; s8_b = t8[k][2]; s8_start = 1'b1;
      e.res = {24'b0, t8[k][3]};
      e.acc = cyc;
      e.lat = (k == 4) ? 1 : 10;
      q8.push_back(e);
      @(negedge clk);
      s8_start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (done8) begin seen = 1'b1; break; end
        @(negedge clk);
      end
      check("x8_done_seen", 32'(seen), 32'd1);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("q32_drained", q32.size(), 0);
    check("q8_drained", q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
